// File: rtl/stopwatch_display_mux.sv
// stopwatch_display_mux
//   Scans the stopwatch's four BCD digits onto a 4-digit common-anode
//   multiplexed seven-segment display. One digit is lit at a time and the
//   scan moves to the next digit every REFRESH_DIV clock cycles.
//
// Parameters
//   REFRESH_DIV    : clock cycles each digit stays lit (>= 1)
//   SEG_ACTIVE_LOW : 1 -> seg/dp pins drive 0 to light a segment
//   AN_ACTIVE_LOW  : 1 -> an pins drive 0 to enable a digit
//
// Ports
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high; clears all state, display dark
//   q0..q3 : BCD digits, q0 rightmost, q3 leftmost
//   seg    : segments {g,f,e,d,c,b,a}, registered
//   dp     : decimal point, lit while digit 2 is scanned (q3q2.q1q0)
//   an     : digit enables, an[i] selects digit i, registered one-hot
//
// Optional feature
//   STOPWATCH_LZ_BLANK_EN : when defined, leading zeros on digits 3..1 are
//   blanked (segments dark, an still rotates, dp still shown on digit 2).

module stopwatch_display_mux #(
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q0,
  input  logic [3:0] q1,
  input  logic [3:0] q2,
  input  logic [3:0] q3,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(REFRESH_DIV - 1);

  // Pin values that mean "nothing lit" for each polarity.
  localparam logic [6:0] SEG_DARK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_DARK  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [3:0] AN_DARK  = AN_ACTIVE_LOW ? 4'hF : 4'h0;

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [1:0]        idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [3:0]        an_q, an_d;

  logic [3:0] cur_digit;
  logic [6:0] lit_mask;
  logic       blank;

  // Digit selected by the current scan index; read live so a mid-slot
  // change of q is visible on the very next edge.
  always_comb begin
    cur_digit = q0;
    case (idx_q)
      2'd0: cur_digit = q0;
      2'd1: cur_digit = q1;
      2'd2: cur_digit = q2;
      2'd3: cur_digit = q3;
      default: cur_digit = q0;
    endcase
  end

  // Logical lit-set {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  always_comb begin
    lit_mask = 7'b1000000;
    case (cur_digit)
      4'd0: lit_mask = 7'b0111111;
      4'd1: lit_mask = 7'b0000110;
      4'd2: lit_mask = 7'b1011011;
      4'd3: lit_mask = 7'b1001111;
      4'd4: lit_mask = 7'b1100110;
      4'd5: lit_mask = 7'b1101101;
      4'd6: lit_mask = 7'b1111101;
      4'd7: lit_mask = 7'b0000111;
      4'd8: lit_mask = 7'b1111111;
      4'd9: lit_mask = 7'b1101111;
      default: lit_mask = 7'b1000000;
    endcase
  end

`ifdef STOPWATCH_LZ_BLANK_EN
  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 is always shown so the display never goes fully blank.
  always_comb begin
    blank = 1'b0;
    case (idx_q)
      2'd3: blank = (q3 == 4'd0);
      2'd2: blank = (q3 == 4'd0) && (q2 == 4'd0);
      2'd1: blank = (q3 == 4'd0) && (q2 == 4'd0) && (q1 == 4'd0);
      default: blank = 1'b0;
    endcase
  end
`else
  always_comb begin
    blank = 1'b0;
  end
`endif

  // Refresh timing and the registered display outputs, computed from the
  // index in effect before this edge's advance.
  always_comb begin
    tick_d = tick_q + TICK_W'(1);
    idx_d  = idx_q;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end

    an_d = AN_ACTIVE_LOW ? ~(4'b0001 << idx_q) : (4'b0001 << idx_q);

    if (blank) begin
      seg_d = SEG_DARK;
    end else begin
      seg_d = SEG_ACTIVE_LOW ? ~lit_mask : lit_mask;
    end

    dp_d = (idx_q == 2'd2) ? ~DP_DARK : DP_DARK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
      idx_q  <= 2'd0;
      seg_q  <= SEG_DARK;
      dp_q   <= DP_DARK;
      an_q   <= AN_DARK;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_stopwatch_display_mux.sv
// tb_stopwatch_display_mux
//   Self-checking bench for stopwatch_display_mux with REFRESH_DIV=4 and
//   active-low segment and anode pins. Expected pin values come from a
//   reference model that works from elapsed edges since reset and from the
//   segment letter lists of each digit.

module tb_stopwatch_display_mux;

  localparam int DIV = 4;

  logic       clk;
  logic       reset;
  logic [3:0] q0, q1, q2, q3;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks;
  int fails;

  // Reference model state
  int         edges;
  int         exp_digit;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [3:0] exp_an;

  string patt [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg",
                       "g", "g", "g", "g", "g", "g"};

  stopwatch_display_mux #(
    .REFRESH_DIV(DIV),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .q0(q0),
    .q1(q1),
    .q2(q2),
    .q3(q3),
    .seg(seg),
    .dp(dp),
    .an(an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment letters -> bit mask {g..a}, then active-low pin value.
  function automatic logic [6:0] pins_for(input logic [3:0] v);
    string      s;
    logic [6:0] m;
    s = patt[v];
    m = '0;
    for (int i = 0; i < s.len(); i++) m[s[i] - "a"] = 1'b1;
    return ~m;
  endfunction

  function automatic logic [3:0] digit_val(input int d);
    case (d)
      0: return q0;
      1: return q1;
      2: return q2;
      default: return q3;
    endcase
  endfunction

  function automatic bit is_blanked(input int d);
    bit all_zero;
    all_zero = (d > 0);
`ifdef STOPWATCH_LZ_BLANK_EN
    for (int j = d; j <= 3; j++) if (digit_val(j) != 4'd0) all_zero = 0;
`else
    all_zero = 0;
`endif
    return all_zero;
  endfunction

  // Advance one clock edge and update the model, then move #1 past the edge.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; edges = 0;
    end else begin
      exp_digit = (edges / DIV) % 4;
      exp_an    = ~(4'b0001 << exp_digit);
      exp_seg   = is_blanked(exp_digit) ? 7'h7F : pins_for(digit_val(exp_digit));
      exp_dp    = (exp_digit == 2) ? 1'b0 : 1'b1;
      edges++;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    q0 = 4'd4; q1 = 4'd3; q2 = 4'd2; q3 = 4'd1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_async an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        fails++;
        $display("[TB] FAIL reset_hold an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
      end
    end
    reset = 1'b0;
    edges = 0;
    #1;
    checks++;
    if (an !== 4'hF) begin
      fails++;
      $display("[TB] FAIL reset_release_dark an=%b want 1111", an);
    end
    step();
    checks++;
    if (an !== 4'b1110) begin
      fails++;
      $display("[TB] FAIL first_edge_an an=%b want 1110", an);
    end
  endtask

  task automatic test_scan();
    int runs [4];
    for (int i = 0; i < 4; i++) runs[i] = 0;
    // complete the first slot, then one full rotation of 16 edges
    for (int i = 0; i < 3 + 16; i++) begin
      step();
      if (i >= 3) runs[exp_digit]++;
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("[TB] FAIL scan an=%b seg=%h dp=%b want %b/%h/%b",
                 an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (an == 4'b1011) begin
        checks++;
        if (seg !== 7'h24 || dp !== 1'b0) begin
          fails++;
          $display("[TB] FAIL scan_digit2 seg=%h dp=%b want 24/0", seg, dp);
        end
      end
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (runs[d] != DIV) begin
        fails++;
        $display("[TB] FAIL slot_len digit%0d got %0d want %0d", d, runs[d], DIV);
      end
    end
  endtask

  task automatic test_live_update();
    int n;
    int guard;
    guard = 0;
    // align to the second edge of a digit-0 slot
    while ((edges % (4 * DIV)) != 1 && guard < 40) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      fails++;
      $display("[TB] FAIL live_align timeout edges=%0d", edges);
    end
    q0 = 4'd9;
    step();
    checks++;
    if (an !== 4'b1110 || seg !== 7'h10) begin
      fails++;
      $display("[TB] FAIL live_update an=%b seg=%h want 1110/10", an, seg);
    end
    n = 2;
    for (int i = 0; i < 6; i++) begin
      step();
      if (an == 4'b1110) n++;
      checks++;
      if (an !== exp_an || seg !== exp_seg) begin
        fails++;
        $display("[TB] FAIL live_follow an=%b seg=%h want %b/%h", an, seg, exp_an, exp_seg);
      end
    end
    checks++;
    if (n != DIV) begin
      fails++;
      $display("[TB] FAIL live_slot_len got %0d want %0d", n, DIV);
    end
  endtask

  task automatic test_non_bcd();
    bit seen;
    seen = 0;
    q1 = 4'hC;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("[TB] FAIL non_bcd an=%b seg=%h dp=%b want %b/%h/%b",
                 an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (an == 4'b1101) begin
        seen = 1;
        checks++;
        if (seg !== 7'h3F) begin
          fails++;
          $display("[TB] FAIL dash seg=%h want 3f", seg);
        end
      end
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL dash_slot never reached");
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    int n;
    guard = 0;
    while (!(an == 4'b1011 && (edges % DIV) == 2) && guard < 40) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 40) begin
      fails++;
      $display("[TB] FAIL reset_mid_align timeout an=%b", an);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_mid_dark an=%b seg=%h dp=%b want 1111/7f/1", an, seg, dp);
    end
    step();
    reset = 1'b0;
    edges = 0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (an == 4'b1110) n++;
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("[TB] FAIL reset_restart an=%b seg=%h dp=%b want %b/%h/%b",
                 an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    checks++;
    if (n != DIV) begin
      fails++;
      $display("[TB] FAIL restart_slot_len got %0d want %0d", n, DIV);
    end
  endtask

  task automatic test_leading_zero();
    logic [6:0] want_hi;
`ifdef STOPWATCH_LZ_BLANK_EN
    want_hi = 7'h7F;
`else
    want_hi = 7'h40;
`endif
    q3 = 4'd0; q2 = 4'd0; q1 = 4'd0; q0 = 4'd7;
    step();
    for (int i = 0; i < 16; i++) begin
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("[TB] FAIL lz_model an=%b seg=%h dp=%b want %b/%h/%b",
                 an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      checks++;
      if (an == 4'b1110 ? (seg !== 7'h78) : (seg !== want_hi)) begin
        fails++;
        $display("[TB] FAIL lz_const an=%b seg=%h", an, seg);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        q0 = 4'($urandom_range(0, 15));
        q1 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        q2 = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        q3 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      step();
      checks++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        fails++;
        $display("[TB] FAIL random q=%h%h%h%h an=%b seg=%h dp=%b want %b/%h/%b",
                 q3, q2, q1, q0, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    edges  = 0;
    exp_digit = 0;
    exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
    test_reset();
    test_scan();
    test_live_update();
    test_non_bcd();
    test_reset_mid();
    test_leading_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
